dma_engine: RTL and testbench
=============================

# dma_engine

Bus-master DMA engine on the far side of the CPU's `dma_req`/`dma_ack` handshake. Requests the system bus, and once the CPU grants it, moves a programmed block of bytes between memory and/or I/O space using the same 22-bit address / rd / wr / mem_io / WAIT bus cycle the CPU uses. Bus tenure is broken into bounded bursts so the CPU is not starved. Sits beside the CPU; its bus outputs are muxed onto the system bus while `dma_ack` is high.

## Interface
- `ADDR_W`, 22, bus address width
- `LEN_W`, 16, transfer length counter width
- `BURST`, 16, max bytes per bus tenure (≥1)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; samples all `cfg_*`
- `cfg_src`  in  ADDR_W  source start address
- `cfg_dst`  in  ADDR_W  destination start address
- `cfg_len`  in  LEN_W  byte count; 0 = no transfer
- `cfg_src_io`, `cfg_dst_io`  in  1  value driven on `bus_mem_io` for read / write phase (1 = I/O)
- `cfg_src_inc`, `cfg_dst_inc`  in  1  post-increment address after each byte
- `dma_req`  out  1  bus request to CPU
- `dma_ack`  in  1  bus grant from CPU
- `WAIT`  in  1  target wait-state, active high
- `data_in`  in  8  read data from bus
- `bus_addr`  out  ADDR_W  address
- `bus_data_out`  out  8  write data
- `bus_rd`, `bus_wr`  out  1  read / write strobes
- `bus_mem_io`  out  1  space select
- `bus_oe`  out  1  high while engine owns bus (mux select)
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, REQ, RD, WR, GAP, FIN.
- IDLE: `start` → latch cfg into src/dst/len regs, clear burst counter; len==0 → FIN, else → REQ. `start` outside IDLE ignored.
- REQ: `dma_req`=1; `dma_ack`=1 sampled → RD.
- RD: `bus_oe`=1, `bus_rd`=1, `bus_addr`=src, `bus_mem_io`=src_io. On edge with `WAIT`=0: latch `data_in` to data reg → WR.
- WR: `bus_wr`=1, `bus_addr`=dst, `bus_mem_io`=dst_io, `bus_data_out`=data reg. On edge with `WAIT`=0: len−1, burst+1, src/dst += inc flag; then len becomes 0 → FIN; `dma_ack`=0 or burst==BURST → GAP; else → RD.
- GAP: `dma_req`=0, `bus_oe`=0 for exactly one cycle, burst cleared → REQ.
- FIN: `dma_req`=0, `done`=1 one cycle → IDLE.
- `busy`=1 in every state except IDLE.
- Address arithmetic modulo 2^ADDR_W (0x3FFFFF+1 → 0x000000). Non-incrementing side keeps a fixed address (I/O port FIFO).
- `dma_ack` drop during RD/WR: current phase completes (byte never half-moved), then GAP.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE; `dma_req`, `bus_rd`, `bus_wr`, `bus_oe`, `bus_mem_io`, `busy`, `done` = 0; `bus_addr`=0, `bus_data_out`=0. Reset mid-transfer aborts without `done`.
- All outputs registered / decoded from state regs; no combinational path from `WAIT` or `data_in` to outputs.
- `start`→`dma_req`: 1 cycle. Grant→first `bus_rd`: 1 cycle after `dma_ack` sampled.
- Zero wait states: 2 cycles/byte; each WAIT-high cycle extends current phase by 1.
- N-byte zero-wait transfer, ack held, N≤BURST: `dma_req` high N·2+1 cycles; `done` 1 cycle after last WR.
- `bus_rd` and `bus_wr` never high together; `bus_oe`=0 whenever `dma_req`=0.

## Structure
- Package `pa_dma`: `e_dma_state` enum, default widths.
- Single module; no sub-module needed.

## Test plan
- src=0x001000, dst=0x002000, len=4, both inc, mem, ack 1 cycle after req, no WAIT → mem[0x2000..3] = mem[0x1000..3]; `done` exactly 10 cycles after grant.
- len=0 → `done` 2 cycles after `start`; `dma_req` never asserted.
- len=40, BURST=16 → exactly 3 grants, 16/16/8 bytes; `dma_req` low one cycle in each GAP.
- src I/O 0x0040 no-inc, WAIT=1 for 3 cycles per read, len=3 → 3 reads all at 0x0040, each RD lasts 4 cycles, `bus_mem_io`=1 only in RD.
- dst=0x3FFFFF, len=2 → second write at 0x000000.
- `rst_n` low during 3rd WR of len=8 → all outputs 0 next edge, no `done`; subsequent `start` runs cleanly.

Source files
------------

// File: rtl/dma_engine_pkg.sv
// dma_engine_pkg: state encoding and default widths for the DMA engine
package pa_dma;
  localparam int ADDR_W_DEF = 22;
  localparam int LEN_W_DEF = 16;
  localparam int BURST_DEF = 16;
  typedef enum logic [2:0] {IDLE, REQ, RD, WR, GAP, FIN} e_dma_state;
endpackage

// File: rtl/dma_engine.sv
// dma_engine: bus-master DMA moving a programmed byte block in bounded bus tenures
module dma_engine
  import pa_dma::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_src_io,
  input  logic              cfg_dst_io,
  input  logic              cfg_src_inc,
  input  logic              cfg_dst_inc,
  output logic              dma_req,
  input  logic              dma_ack,
  input  logic              WAIT,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_data_out,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic              bus_mem_io,
  output logic              bus_oe,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(BURST + 1);
  e_dma_state state;
  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0] len;
  logic [BW-1:0] burst;
  logic [7:0] data;
  logic src_io, dst_io, src_inc, dst_inc;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else
      case (state)
        IDLE: if (start) begin
          src <= cfg_src;
          dst <= cfg_dst;
          len <= cfg_len;
          src_io <= cfg_src_io;
          dst_io <= cfg_dst_io;
          src_inc <= cfg_src_inc;
          dst_inc <= cfg_dst_inc;
          burst <= '0;
          state <= cfg_len == '0 ? FIN : REQ;
        end
        REQ: if (dma_ack) state <= RD;
        RD: if (!WAIT) begin
          data <= data_in;
          state <= WR;
        end
        WR: if (!WAIT) begin
          len <= len - LEN_W'(1);
          burst <= burst + BW'(1);
          src <= src + ADDR_W'(src_inc);
          dst <= dst + ADDR_W'(dst_inc);
          state <= len == LEN_W'(1) ? FIN : (!dma_ack || burst == BW'(BURST - 1)) ? GAP : RD;
        end
        GAP: begin
          burst <= '0;
          state <= REQ;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
  assign dma_req = state inside {REQ, RD, WR};
  assign bus_oe = state inside {RD, WR};
  assign bus_rd = state == RD;
  assign bus_wr = state == WR;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign bus_addr = state == RD ? src : state == WR ? dst : '0;
  assign bus_data_out = state == WR ? data : '0;
  assign bus_mem_io = (state == RD && src_io) || (state == WR && dst_io);
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: randomized bus-level check of dma_engine against a byte-copy model
module tb_dma_engine;
  localparam int BURST = 16;
  localparam int W_REQ = 1, W_RD = 2, W_WR = 3, W_GAP = 4, W_DONE = 5, W_IDLE = 6;
  logic clk = 0, rst_n = 0, start = 0;
  logic [21:0] cfg_src = 0, cfg_dst = 0;
  logic [15:0] cfg_len = 0;
  logic cfg_src_io = 0, cfg_dst_io = 0, cfg_src_inc = 0, cfg_dst_inc = 0;
  logic dma_req, dma_ack = 0, WAIT = 0;
  logic [7:0] data_in = 0;
  logic [21:0] bus_addr;
  logic [7:0] bus_data_out;
  logic bus_rd, bus_wr, bus_mem_io, bus_oe, busy, done;
  int checks = 0, failures = 0;
  logic [7:0] mem_m[int], mem_i[int];
  int amode = 0, wmode = 0, rd_len = 0;
  logic req_prev = 0;
  int cyc = 0, want = W_IDLE, n_len = 0, ri = 0, wi = 0, tcount = 0, grants = 0, n_done = 0;
  int start_cyc = 0, done_cyc = 0, grant_cyc = -1, req_cyc = 0, io_out = 0, io_rd = 0, rdrun = 0;
  bit xb = 0, rs = 0;
  logic sio = 0, dio = 0;
  int ra_q[$], wa_q[$], ten[$], rdl[$], wa_log[$], rd_log[$];
  logic [7:0] wd_q[$];
  logic [7:0] ov_m[int], ov_i[int];

  always #5 clk = ~clk;

  dma_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
    .cfg_len(cfg_len), .cfg_src_io(cfg_src_io), .cfg_dst_io(cfg_dst_io),
    .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc), .dma_req(dma_req),
    .dma_ack(dma_ack), .WAIT(WAIT), .data_in(data_in), .bus_addr(bus_addr),
    .bus_data_out(bus_data_out), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_mem_io(bus_mem_io), .bus_oe(bus_oe), .busy(busy), .done(done)
  );

  function automatic logic [7:0] rd_mem(input logic io, input int a);
    if (io) return mem_i.exists(a) ? mem_i[a] : a[7:0] ^ 8'h3C;
    return mem_m.exists(a) ? mem_m[a] : a[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // CPU grant with one cycle latency, target wait states and read data
  initial forever begin
    @(posedge clk); #1;
    dma_ack = req_prev && !(amode == 1 && $urandom_range(0, 4) == 0);
    req_prev = dma_req;
    rd_len = bus_rd ? rd_len + 1 : 0;
    WAIT = wmode == 1 ? (bus_rd && rd_len <= 3) : wmode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
    data_in = bus_rd ? rd_mem(bus_mem_io, int'(bus_addr)) : 8'($urandom);
  end

  // per-cycle compare against the byte-copy model
  always @(negedge clk) begin
    int ra, wa;
    logic [7:0] d;
    cyc++;
    if (!rst_n) begin
      rs = 1;
      xb = 0;
      want = W_IDLE;
    end else begin
      if (rs) begin
        chk({dma_req, bus_rd, bus_wr, bus_oe, bus_mem_io, busy, done} == 7'b0, "reset_ctl",
            {dma_req, bus_rd, bus_wr, bus_oe, bus_mem_io, busy, done}, 0);
        chk(bus_addr == 0 && bus_data_out == 0, "reset_bus", {bus_addr, bus_data_out}, 0);
        rs = 0;
      end
      chk(!(bus_rd && bus_wr), "rd_wr_overlap", {bus_rd, bus_wr}, 0);
      chk(bus_oe == (bus_rd || bus_wr) && !(bus_oe && !dma_req), "oe_decode",
          {dma_req, bus_oe}, {dma_req, bus_rd | bus_wr});
      chk(busy == xb, "busy", busy, xb);
      chk(done == (want == W_DONE), "done", done, want == W_DONE);
      if (!bus_oe) chk(!bus_mem_io, "mem_io_idle", bus_mem_io, 0);
      case (want)
        W_REQ: chk(dma_req && !bus_oe, "req_phase", {dma_req, bus_oe}, 2'b10);
        W_RD: chk(bus_rd && dma_req, "rd_phase", {dma_req, bus_rd, bus_wr}, 3'b110);
        W_WR: chk(bus_wr && dma_req, "wr_phase", {dma_req, bus_rd, bus_wr}, 3'b101);
        W_GAP: chk(!dma_req && !bus_oe && busy, "gap_phase", {dma_req, bus_oe, busy}, 3'b001);
        W_DONE: chk(!dma_req && !bus_oe && busy, "fin_phase", {dma_req, bus_oe, busy}, 3'b001);
        W_IDLE: chk(!dma_req && !busy, "idle_phase", {dma_req, busy}, 0);
        default: ;
      endcase
      if (bus_rd)
        chk(ri < ra_q.size() && int'(bus_addr) == ra_q[ri] && bus_mem_io == sio, "rd_addr",
            {bus_mem_io, bus_addr}, ri < ra_q.size() ? {sio, 22'(ra_q[ri])} : -1);
      if (bus_wr)
        chk(wi < wa_q.size() && int'(bus_addr) == wa_q[wi] && bus_mem_io == dio
            && bus_data_out == wd_q[wi], "wr_addr_data", {bus_mem_io, bus_addr, bus_data_out},
            wi < wa_q.size() ? {dio, 22'(wa_q[wi]), wd_q[wi]} : -1);
      if (dma_req) req_cyc++;
      if (bus_mem_io && !bus_rd) io_out++;
      if (bus_mem_io && bus_rd) io_rd++;
      if (start && !xb) begin
        n_len = int'(cfg_len);
        sio = cfg_src_io;
        dio = cfg_dst_io;
        ra_q.delete(); wa_q.delete(); wd_q.delete(); ov_m.delete(); ov_i.delete();
        ten.delete(); rdl.delete(); wa_log.delete(); rd_log.delete();
        for (int i = 0; i < n_len; i++) begin
          ra = (int'(cfg_src) + (cfg_src_inc ? i : 0)) % 4194304;
          wa = (int'(cfg_dst) + (cfg_dst_inc ? i : 0)) % 4194304;
          if (sio) d = ov_i.exists(ra) ? ov_i[ra] : rd_mem(1, ra);
          else d = ov_m.exists(ra) ? ov_m[ra] : rd_mem(0, ra);
          if (dio) ov_i[wa] = d;
          else ov_m[wa] = d;
          ra_q.push_back(ra);
          wa_q.push_back(wa);
          wd_q.push_back(d);
        end
        ri = 0; wi = 0; tcount = 0; grants = 0; grant_cyc = -1;
        req_cyc = 0; io_out = 0; io_rd = 0; rdrun = 0;
        start_cyc = cyc;
        xb = 1;
        want = n_len == 0 ? W_DONE : W_REQ;
      end else if (done) begin
        if (tcount > 0) ten.push_back(tcount);
        tcount = 0;
        n_done++;
        done_cyc = cyc;
        xb = 0;
        want = W_IDLE;
      end else if (bus_rd) begin
        if (WAIT) rdrun++;
        else begin
          rdl.push_back(rdrun + 1);
          rd_log.push_back(int'(bus_addr));
          rdrun = 0;
          ri++;
        end
        want = WAIT ? W_RD : W_WR;
      end else if (bus_wr) begin
        if (WAIT) want = W_WR;
        else begin
          if (bus_mem_io) mem_i[int'(bus_addr)] = bus_data_out;
          else mem_m[int'(bus_addr)] = bus_data_out;
          wa_log.push_back(int'(bus_addr));
          wi++;
          tcount++;
          if (wi >= n_len) want = W_DONE;
          else if (!dma_ack || tcount == BURST) begin
            ten.push_back(tcount);
            tcount = 0;
            want = W_GAP;
          end else want = W_RD;
        end
      end else if (xb && dma_req) begin
        if (dma_ack) begin
          grants++;
          if (grant_cyc < 0) grant_cyc = cyc;
        end
        want = dma_ack ? W_RD : W_REQ;
      end else if (xb) want = W_REQ;
      else want = W_IDLE;
    end
  end

  task automatic run(input logic [21:0] s, input logic [21:0] d, input logic [15:0] l,
                     input logic si, input logic di, input logic sn, input logic dn,
                     input int am, input int wm, input bit stray);
    int nd0, k;
    amode = am;
    wmode = wm;
    @(posedge clk); #1;
    cfg_src = s; cfg_dst = d; cfg_len = l;
    cfg_src_io = si; cfg_dst_io = di; cfg_src_inc = sn; cfg_dst_inc = dn;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    nd0 = n_done;
    k = 0;
    while (n_done == nd0 && k < 4000) begin
      if (stray && busy && !done && $urandom_range(0, 20) == 0) begin
        cfg_src = 22'($urandom);
        cfg_len = 16'($urandom_range(0, 5));
        start = 1;
      end else start = 0;
      @(posedge clk); #1;
      k++;
    end
    start = 0;
    chk(n_done != nd0, "done_timeout", k, 4000);
    if (n_done == nd0) begin
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [21:0] s, dd;
    logic [15:0] l;
    int nd0, k;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    run(22'h001000, 22'h002000, 16'd4, 0, 0, 1, 1, 0, 0, 0);
    chk(done_cyc - grant_cyc + 1 == 10, "A_grant_to_done", done_cyc - grant_cyc + 1, 10);
    chk(grants == 1, "A_grants", grants, 1);
    chk(rd_mem(0, 'h2000) == 8'hA5, "A_mem0", rd_mem(0, 'h2000), 8'hA5);
    chk(rd_mem(0, 'h2003) == 8'hA6, "A_mem3", rd_mem(0, 'h2003), 8'hA6);
    run(22'h000100, 22'h000200, 16'd0, 0, 0, 1, 1, 0, 0, 0);
    chk(done_cyc - start_cyc + 1 == 2, "B_start_to_done", done_cyc - start_cyc + 1, 2);
    chk(req_cyc == 0, "B_no_req", req_cyc, 0);
    run(22'h010000, 22'h020000, 16'd40, 0, 0, 1, 1, 0, 0, 0);
    chk(grants == 3, "C_grants", grants, 3);
    chk(ten.size() == 3 && ten[0] == 16 && ten[1] == 16 && ten[2] == 8, "C_tenures",
        ten.size() == 3 ? {ten[0][7:0], ten[1][7:0], ten[2][7:0]} : ten.size(), 24'h101008);
    run(22'h000040, 22'h005000, 16'd3, 1, 0, 0, 1, 0, 1, 0);
    chk(rdl.size() == 3 && rdl[0] == 4 && rdl[1] == 4 && rdl[2] == 4, "D_rd_len",
        rdl.size() == 3 ? {rdl[0][7:0], rdl[1][7:0], rdl[2][7:0]} : rdl.size(), 24'h040404);
    chk(rd_log.size() == 3 && rd_log[2] == 'h40, "D_rd_addr", rd_log.size() == 3 ? rd_log[2] : -1, 'h40);
    chk(io_rd == 12 && io_out == 0, "D_mem_io", {io_rd[7:0], io_out[7:0]}, 16'h0C00);
    chk(rd_mem(0, 'h5002) == 8'h7C, "D_mem", rd_mem(0, 'h5002), 8'h7C);
    run(22'h000300, 22'h3FFFFF, 16'd2, 0, 0, 1, 1, 0, 0, 0);
    chk(wa_log.size() == 2 && wa_log[0] == 'h3FFFFF, "E_wr0", wa_log.size() > 0 ? wa_log[0] : -1, 'h3FFFFF);
    chk(wa_log.size() == 2 && wa_log[1] == 0, "E_wrap", wa_log.size() > 1 ? wa_log[1] : -1, 0);
    amode = 0;
    wmode = 0;
    @(posedge clk); #1;
    cfg_src = 22'h000800; cfg_dst = 22'h000900; cfg_len = 16'd8;
    cfg_src_io = 0; cfg_dst_io = 0; cfg_src_inc = 1; cfg_dst_inc = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (!(bus_wr && wi == 2) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk(k < 200, "F_reach_wr3", k, 200);
    nd0 = n_done;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk(n_done == nd0, "F_no_done", n_done, nd0);
    run(22'h000800, 22'h000900, 16'd8, 0, 0, 1, 1, 0, 2, 0);
    chk(wa_log.size() == 8, "F_rerun_bytes", wa_log.size(), 8);
    for (int t = 0; t < 40; t++) begin
      s = $urandom_range(0, 3) == 0 ? 22'h3FFFF0 + 22'($urandom_range(0, 15)) : 22'($urandom);
      dd = $urandom_range(0, 3) == 0 ? 22'h3FFFF0 + 22'($urandom_range(0, 15)) : 22'($urandom);
      l = $urandom_range(0, 7) == 0 ? 16'd0 : 16'($urandom_range(1, 40));
      run(s, dd, l, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 1) * 2, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
